reg_target: RTL and testbench

- Register-bank responder on the reg_if rsp side: consumes op/addr/wdata from a requester and returns rdata.
- Holds a small control/status register map: ID, control, sticky W1C status with interrupt mask, a free-running event counter, and scratch registers.
- Sits directly downstream of the reg_if requester/agent; the mon side observes the same signals.

---
 rtl/reg_target_pkg.sv | 19 +
 rtl/reg_target_cnt.sv | 30 +++
 rtl/reg_target.sv | 143 ++++++++++++++
 tb/tb_reg_target.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_target_pkg.sv
// Shared encodings for the reg_target register responder: op codes, register
// addresses and CTRL bit positions.
package reg_target_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;

    localparam int unsigned ADDR_ID           = 32'h00;
    localparam int unsigned ADDR_CTRL         = 32'h01;
    localparam int unsigned ADDR_STATUS       = 32'h02;
    localparam int unsigned ADDR_CNT          = 32'h03;
    localparam int unsigned ADDR_MASK         = 32'h04;
    localparam int unsigned ADDR_SCRATCH_BASE = 32'h08;

    localparam int unsigned CTRL_CNT_EN  = 0;
    localparam int unsigned CTRL_CNT_CLR = 1;

endpackage

// File: rtl/reg_target_cnt.sv
// Free-running event counter with enable and synchronous clear; wrap pulses
// combinationally in the cycle the counter rolls over from all-ones to zero.
module reg_target_cnt #(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    output logic [DWIDTH-1:0] count,
    output logic              wrap
);

    logic [DWIDTH-1:0] count_reg;

    // Clear has priority, so a clear cycle can never report a wrap.
    assign wrap  = en && !clr && (count_reg == '1);
    assign count = count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + DWIDTH'(1);
        end
    end

endmodule

// File: rtl/reg_target.sv
// Register-bank responder: ID, CTRL, W1C STATUS with MASK/irq, event counter
// and scratch registers. Define REG_TARGET_ERR_EN to add the err output.
module reg_target
    import reg_target_pkg::*;
#(
    parameter int         DWIDTH      = 8,
    parameter int         AWIDTH      = 8,
    parameter int         NUM_SCRATCH = 4,
    parameter logic [7:0] ID_VALUE    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        op,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata,
    input  logic [DWIDTH-1:0] sts_set,
    output logic              irq
`ifdef REG_TARGET_ERR_EN
    ,
    output logic              err
`endif
);

    logic rd_op;
    logic wr_op;
    assign rd_op = (op == OP_RD);
    assign wr_op = (op == OP_WR);

    logic hit_id, hit_ctrl, hit_status, hit_cnt, hit_mask;
    logic [NUM_SCRATCH-1:0] hit_scratch;
    assign hit_id     = (addr == AWIDTH'(ADDR_ID));
    assign hit_ctrl   = (addr == AWIDTH'(ADDR_CTRL));
    assign hit_status = (addr == AWIDTH'(ADDR_STATUS));
    assign hit_cnt    = (addr == AWIDTH'(ADDR_CNT));
    assign hit_mask   = (addr == AWIDTH'(ADDR_MASK));

    logic [DWIDTH-1:0] ctrl_reg;
    logic [DWIDTH-1:0] status_reg;
    logic [DWIDTH-1:0] mask_reg;
    logic [DWIDTH-1:0] rdata_reg;
    logic              irq_reg;
    logic [DWIDTH-1:0] scratch_reg [NUM_SCRATCH];

    logic [DWIDTH-1:0] status_next;
    logic [DWIDTH-1:0] mask_next;
    logic [DWIDTH-1:0] rd_value;
    logic [DWIDTH-1:0] count;
    logic              cnt_clr;
    logic              wrap;

    assign cnt_clr = wr_op && hit_ctrl && wdata[CTRL_CNT_CLR];

    reg_target_cnt #(
        .DWIDTH(DWIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (ctrl_reg[CTRL_CNT_EN]),
        .clr   (cnt_clr),
        .count (count),
        .wrap  (wrap)
    );

    for (genvar gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scratch
        assign hit_scratch[gi] = (addr == AWIDTH'(ADDR_SCRATCH_BASE + gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                scratch_reg[gi] <= '0;
            end else if (wr_op && hit_scratch[gi]) begin
                scratch_reg[gi] <= wdata;
            end
        end
    end

    // Sets (event pulses and counter wrap) override a same-cycle W1C clear.
    always_comb begin
        status_next = status_reg;
        if (wr_op && hit_status) begin
            status_next = status_reg & ~wdata;
        end
        status_next = status_next | sts_set;
        if (wrap) begin
            status_next[0] = 1'b1;
        end
    end

    assign mask_next = (wr_op && hit_mask) ? wdata : mask_reg;

`ifdef REG_TARGET_ERR_EN
    logic mapped;
    logic err_reg;
    assign mapped = hit_id | hit_ctrl | hit_status | hit_cnt | hit_mask | (|hit_scratch);
    assign err    = err_reg;
`endif

    always_comb begin
        rd_value = '0;
        if (hit_id)     rd_value = DWIDTH'(ID_VALUE);
        if (hit_ctrl)   rd_value = ctrl_reg;
        if (hit_status) rd_value = status_reg;
        if (hit_cnt)    rd_value = count;
        if (hit_mask)   rd_value = mask_reg;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (hit_scratch[i]) rd_value = scratch_reg[i];
        end
`ifdef REG_TARGET_ERR_EN
        if (!mapped) rd_value = '1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_reg   <= '0;
            status_reg <= '0;
            mask_reg   <= '0;
            rdata_reg  <= '0;
            irq_reg    <= 1'b0;
`ifdef REG_TARGET_ERR_EN
            err_reg    <= 1'b0;
`endif
        end else begin
            // The clear bit is a pulse and is never stored.
            if (wr_op && hit_ctrl) begin
                ctrl_reg <= wdata & ~(DWIDTH'(1) << CTRL_CNT_CLR);
            end
            status_reg <= status_next;
            mask_reg   <= mask_next;
            irq_reg    <= |(status_next & mask_next);
            if (rd_op) begin
                rdata_reg <= rd_value;
            end
`ifdef REG_TARGET_ERR_EN
            err_reg <= ((rd_op || wr_op) && !mapped) || (wr_op && (hit_id || hit_cnt));
`endif
        end
    end

    assign rdata = rdata_reg;
    assign irq   = irq_reg;

endmodule

// File: tb/tb_reg_target.sv
// Randomized scoreboard bench for reg_target: a reference model predicts the
// per-cycle rdata/irq(/err) and a separate monitor compares after each edge.
module tb_reg_target;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] op = 2'b00;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] sts_set = 8'h00;
    logic [7:0] rdata;
    logic       irq;
`ifdef REG_TARGET_ERR_EN
    logic       err;
`endif

    always #5 clk = ~clk;

    reg_target dut (
        .clk     (clk),
        .rst     (rst),
        .op      (op),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .sts_set (sts_set),
        .irq     (irq)
`ifdef REG_TARGET_ERR_EN
        ,
        .err     (err)
`endif
    );

    typedef struct {
        logic [7:0] rdata;
        logic       irq;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: what software would see in each register.
    bit [7:0] m_ctrl;
    bit [7:0] m_status;
    bit [7:0] m_mask;
    bit [7:0] m_cnt;
    bit [7:0] m_scratch [4];
    bit [7:0] m_rdata;

    function automatic bit [7:0] model_read(input bit [7:0] a, output bit mapped);
        mapped = 1'b1;
        if (a == 8'h00) return 8'hA5;
        if (a == 8'h01) return m_ctrl;
        if (a == 8'h02) return m_status;
        if (a == 8'h03) return m_cnt;
        if (a == 8'h04) return m_mask;
        if (a >= 8'h08 && a < 8'h0C) return m_scratch[a - 8'h08];
        mapped = 1'b0;
`ifdef REG_TARGET_ERR_EN
        return 8'hFF;
`else
        return 8'h00;
`endif
    endfunction

    task automatic model_step(input bit r, input bit [1:0] o, input bit [7:0] a,
                              input bit [7:0] w, input bit [7:0] s);
        exp_t e;
        bit   mapped;
        bit   is_rd;
        bit   is_wr;
        bit   clr;
        bit   wrapped;
        bit [7:0] val;
        e.err = 1'b0;
        if (r) begin
            m_ctrl = 0; m_status = 0; m_mask = 0; m_cnt = 0; m_rdata = 0;
            for (int i = 0; i < 4; i++) m_scratch[i] = 0;
        end else begin
            is_rd = (o == 2'd1);
            is_wr = (o == 2'd2);
            val = model_read(a, mapped);
            if (is_rd) m_rdata = val;
            e.err = ((is_rd || is_wr) && !mapped) || (is_wr && (a == 8'h00 || a == 8'h03));
            clr = is_wr && (a == 8'h01) && w[1];
            wrapped = 1'b0;
            if (clr) begin
                m_cnt = 0;
            end else if (m_ctrl[0]) begin
                wrapped = (m_cnt == 8'd255);
                m_cnt = 8'((int'(m_cnt) + 1) % 256);
            end
            if (is_wr && a == 8'h02) m_status = m_status & ~w;
            m_status = m_status | s | {7'd0, wrapped};
            if (is_wr && a == 8'h01) m_ctrl = w & 8'hFD;
            if (is_wr && a == 8'h04) m_mask = w;
            if (is_wr && a >= 8'h08 && a < 8'h0C) m_scratch[a - 8'h08] = w;
        end
        e.rdata = m_rdata;
        e.irq   = r ? 1'b0 : |(m_status & m_mask);
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit r, input bit [1:0] o, input bit [7:0] a,
                         input bit [7:0] w, input bit [7:0] s);
        @(negedge clk);
        rst = r; op = o; addr = a; wdata = w; sts_set = s;
        if (r || o == 2'd1 || o == 2'd2)
            $display("txn rst=%0d op=%0d addr=%02h wdata=%02h sts_set=%02h", r, o, a, w, s);
        model_step(r, o, a, w, s);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every edge yields one expected response, compared 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rdata", rdata, e.rdata);
                check("irq", {7'd0, irq}, {7'd0, e.irq});
`ifdef REG_TARGET_ERR_EN
                check("err", {7'd0, err}, {7'd0, e.err});
`endif
            end
        end
    end

    localparam bit [1:0] NOP = 2'd0, RD = 2'd1, WR = 2'd2;

    initial begin
        bit [7:0] addr_pool [16];
        addr_pool = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h07, 8'h08,
                      8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h40, 8'hFF, 8'h02, 8'h03};

        // Reset and ID/CNT reads
        drive(1, NOP, 8'h00, 8'h00, 8'h00);
        drive(1, NOP, 8'h00, 8'h00, 8'h00);
        drive(0, RD, 8'h00, 8'h00, 8'h00);
        drive(0, RD, 8'h03, 8'h00, 8'h00);
        drive(0, NOP, 8'h00, 8'h00, 8'h00);

        // Scratch, RO write, unmapped read
        drive(0, WR, 8'h08, 8'h3C, 8'h00);
        drive(0, WR, 8'h0B, 8'hC3, 8'h00);
        drive(0, RD, 8'h08, 8'h00, 8'h00);
        drive(0, RD, 8'h0B, 8'h00, 8'h00);
        drive(0, WR, 8'h00, 8'hFF, 8'h00);
        drive(0, RD, 8'h00, 8'h00, 8'h00);
        drive(0, RD, 8'h40, 8'h00, 8'h00);
        drive(0, NOP, 8'h00, 8'h00, 8'h00);

        // Counter: enable, run, clear, then full wrap
        drive(0, WR, 8'h01, 8'h01, 8'h00);
        repeat (10) drive(0, NOP, 8'h00, 8'h00, 8'h00);
        drive(0, RD, 8'h03, 8'h00, 8'h00);
        drive(0, WR, 8'h01, 8'h03, 8'h00);
        drive(0, RD, 8'h03, 8'h00, 8'h00);
        drive(0, RD, 8'h01, 8'h00, 8'h00);
        repeat (256) drive(0, NOP, 8'h00, 8'h00, 8'h00);
        drive(0, RD, 8'h02, 8'h00, 8'h00);
        drive(0, WR, 8'h01, 8'h02, 8'h00);
        drive(0, WR, 8'h02, 8'hFF, 8'h00);
        drive(0, RD, 8'h02, 8'h00, 8'h00);

        // Mask / irq set and clear
        drive(0, WR, 8'h04, 8'h04, 8'h00);
        drive(0, NOP, 8'h00, 8'h00, 8'h04);
        drive(0, NOP, 8'h00, 8'h00, 8'h00);
        drive(0, WR, 8'h02, 8'h04, 8'h00);
        drive(0, RD, 8'h02, 8'h00, 8'h00);

        // Set beats clear in the same cycle
        drive(0, NOP, 8'h00, 8'h00, 8'h02);
        drive(0, WR, 8'h02, 8'h02, 8'h02);
        drive(0, RD, 8'h02, 8'h00, 8'h00);

        // Reset during a write
        drive(0, RD, 8'h00, 8'h00, 8'h00);
        drive(1, WR, 8'h09, 8'h55, 8'h00);
        drive(0, RD, 8'h09, 8'h00, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit       r;
            bit [1:0] o;
            bit [7:0] a;
            bit [7:0] s;
            r = ($urandom_range(0, 99) == 0);
            o = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 9) == 0) ? 8'($urandom) : addr_pool[$urandom_range(0, 15)];
            s = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
            drive(r, o, a, 8'($urandom), s);
        end
        drive(0, NOP, 8'h00, 8'h00, 8'h00);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
